// File: rtl/aes_selftest_manager.sv
// aes_selftest_manager: runs the external encrypt and decrypt cores for one key
// size, or for all three in turn. It keeps the ciphertext and the recovered
// plaintext, compares the plaintext with the reference block, drives the
// per-key-size pass/fail LEDs, and scrolls the selected result a byte at a time
// for the display.
module aes_selftest_manager #(
  parameter int DATA_W        = 128,
  parameter int TIMEOUT       = 64,
  parameter int SCROLL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [1:0]        sel,
  input  logic              disp_sel,
  input  logic [DATA_W-1:0] ref_block,
  output logic [1:0]        key_len,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [DATA_W-1:0] enc_data,
  output logic              dec_start,
  output logic [DATA_W-1:0] dec_in,
  input  logic              dec_done,
  input  logic [DATA_W-1:0] dec_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        pass,
  output logic [2:0]        fail,
  output logic [7:0]        disp_byte
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int SC_W  = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, ENC_START, ENC_WAIT, DEC_START, DEC_WAIT, CHECK, NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        m_q, m_d;
  logic [1:0]        key_len_q, key_len_d;
  logic              enc_start_q, enc_start_d;
  logic              dec_start_q, dec_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        pass_q, pass_d;
  logic [2:0]        fail_q, fail_d;
  logic [DATA_W-1:0] cipher_q, cipher_d;
  logic [DATA_W-1:0] plain_q, plain_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Next-state logic. The registered outputs are derived from the next state,
  // so a start pulse shows up in the same cycle that its START state is entered.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    m_d      = m_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    done_d   = done_q;
    cipher_d = cipher_q;
    plain_d  = plain_q;
    wd_d     = wd_q;
    sc_d     = sc_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          mode_d  = sel;
          m_d     = (sel == 2'b11) ? 2'd0 : sel;
          pass_d  = 3'b000;
          fail_d  = 3'b000;
          done_d  = 1'b0;
          idx_d   = '0;
          sc_d    = '0;
          state_d = ENC_START;
        end else if (done_q) begin
          // The display scrolls only while a finished result is on show.
          if (sc_q == SC_LAST) begin
            sc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            sc_d = sc_q + SC_W'(1);
          end
        end
      end
      ENC_START: begin
        wd_d    = '0;
        state_d = ENC_WAIT;
      end
      ENC_WAIT: begin
        // If done arrives in the timeout cycle, done takes priority.
        if (enc_done) begin
          cipher_d = enc_data;
          state_d  = DEC_START;
        end else if (wd_q == WD_LAST) begin
          fail_d[m_q] = 1'b1;
          state_d     = NEXT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      DEC_START: begin
        wd_d    = '0;
        state_d = DEC_WAIT;
      end
      DEC_WAIT: begin
        if (dec_done) begin
          plain_d = dec_data;
          state_d = CHECK;
        end else if (wd_q == WD_LAST) begin
          fail_d[m_q] = 1'b1;
          state_d     = NEXT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      CHECK: begin
        if (plain_q == ref_block) pass_d[m_q] = 1'b1;
        else                      fail_d[m_q] = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (mode_q == 2'b11 && m_q < 2'd2) begin
          m_d     = m_q + 2'd1;
          state_d = ENC_START;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    enc_start_d = (state_d == ENC_START);
    dec_start_d = (state_d == DEC_START);
    busy_d      = (state_d != IDLE);
    key_len_d   = busy_d ? m_d : 2'd0;
  end

  // State and output registers. The asynchronous reset aborts any run at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      m_q         <= 2'd0;
      key_len_q   <= 2'd0;
      enc_start_q <= 1'b0;
      dec_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 3'b000;
      fail_q      <= 3'b000;
      cipher_q    <= '0;
      plain_q     <= '0;
      wd_q        <= '0;
      sc_q        <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      m_q         <= m_d;
      key_len_q   <= key_len_d;
      enc_start_q <= enc_start_d;
      dec_start_q <= dec_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      cipher_q    <= cipher_d;
      plain_q     <= plain_d;
      wd_q        <= wd_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
    end
  end

  // Split both result registers into bytes (byte 0 = bits [7:0]) for the display mux.
  logic [7:0] cipher_bytes [NB];
  logic [7:0] plain_bytes  [NB];
  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign cipher_bytes[gi] = cipher_q[8*gi +: 8];
    assign plain_bytes[gi]  = plain_q[8*gi +: 8];
  end

  assign disp_byte = disp_sel ? plain_bytes[idx_q] : cipher_bytes[idx_q];
  assign key_len   = key_len_q;
  assign enc_start = enc_start_q;
  assign dec_start = dec_start_q;
  assign dec_in    = cipher_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_aes_selftest_manager.sv
// Testbench for aes_selftest_manager: a core stub answers the start pulses with
// configurable latencies and data, and a run-level model predicts pass/fail,
// the run length and the displayed bytes.
module tb_aes_selftest_manager;
  localparam int DW  = 128;
  localparam int TO  = 16;
  localparam int TO8 = 8;
  localparam int SC  = 4;
  localparam int NB  = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0, go8 = 1'b0, disp_sel = 1'b0;
  logic [1:0]    sel = 2'd0, sel8 = 2'd0;
  logic [DW-1:0] ref_block = '0, enc_data = '0, dec_data = '0;
  logic          enc_done = 1'b0, dec_done = 1'b0;
  logic          enc_done8 = 1'b0, dec_done8 = 1'b0;

  logic [1:0]    key_len, key_len8;
  logic          enc_start, dec_start, busy, done;
  logic          enc_start8, dec_start8, busy8, done8;
  logic [DW-1:0] dec_in, dec_in8;
  logic [2:0]    pass, fail, pass8, fail8;
  logic [7:0]    disp_byte, disp_byte8;

  aes_selftest_manager #(.DATA_W(DW), .TIMEOUT(TO), .SCROLL_CYCLES(SC)) u_dut (
    .clk(clk), .reset(reset), .go(go), .sel(sel), .disp_sel(disp_sel),
    .ref_block(ref_block), .key_len(key_len), .enc_start(enc_start),
    .enc_done(enc_done), .enc_data(enc_data), .dec_start(dec_start),
    .dec_in(dec_in), .dec_done(dec_done), .dec_data(dec_data), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .disp_byte(disp_byte));

  // Second instance with a short watchdog and cores that never answer.
  aes_selftest_manager #(.DATA_W(DW), .TIMEOUT(TO8), .SCROLL_CYCLES(SC)) u_dut8 (
    .clk(clk), .reset(reset), .go(go8), .sel(sel8), .disp_sel(disp_sel),
    .ref_block(ref_block), .key_len(key_len8), .enc_start(enc_start8),
    .enc_done(enc_done8), .enc_data(enc_data), .dec_start(dec_start8),
    .dec_in(dec_in8), .dec_done(dec_done8), .dec_data(dec_data), .busy(busy8),
    .done(done8), .pass(pass8), .fail(fail8), .disp_byte(disp_byte8));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Core stub configuration, indexed by key size.
  int            enc_lat [3];
  int            dec_lat [3];
  bit            enc_en  [3];
  logic [DW-1:0] cipher_tab [3];
  logic [DW-1:0] err_tab    [3];
  int            enc_cnt = -1, dec_cnt = -1, enc_k = 0, dec_k = 0;
  int            n_enc = 0, n_dec = 0;
  int            klog [$];
  logic [DW-1:0] dlog [$];
  logic [DW-1:0] mdl_cipher = '0, mdl_plain = '0;

  // Core stub: done comes L cycles after the start pulse, where L is the configured latency.
  initial forever begin
    @(negedge clk);
    enc_done = 1'b0;
    dec_done = 1'b0;
    if (reset) begin
      enc_cnt = -1;
      dec_cnt = -1;
    end else begin
      if (enc_cnt > 0) begin
        enc_cnt--;
        if (enc_cnt == 0) begin
          enc_done = enc_en[enc_k];
          enc_data = cipher_tab[enc_k];
          enc_cnt  = -1;
        end
      end
      if (dec_cnt > 0) begin
        dec_cnt--;
        if (dec_cnt == 0) begin
          dec_done = 1'b1;
          dec_data = ref_block ^ err_tab[dec_k];
          dec_cnt  = -1;
        end
      end
      if (enc_start) begin
        klog.push_back(int'(key_len));
        enc_k   = (key_len > 2'd2) ? 2 : int'(key_len);
        enc_cnt = enc_lat[enc_k];
        n_enc++;
      end
      if (dec_start) begin
        dlog.push_back(dec_in);
        dec_k   = (key_len > 2'd2) ? 2 : int'(key_len);
        dec_cnt = dec_lat[dec_k];
        n_dec++;
      end
    end
  end

  // Run-level reference model: outcome, busy length and latched data per key size.
  task automatic model(input logic [1:0] mode, output logic [2:0] ep, output logic [2:0] ef,
                       output int elen, output int ne, output int nd);
    int first, last;
    first = (mode == 2'b11) ? 0 : int'(mode);
    last  = (mode == 2'b11) ? 2 : int'(mode);
    ep = 3'b000; ef = 3'b000; elen = 0; ne = 0; nd = 0;
    for (int k = first; k <= last; k++) begin
      ne++;
      if (!enc_en[k] || enc_lat[k] > TO) begin
        ef[k] = 1'b1;
        elen += TO + 2;
      end else begin
        mdl_cipher = cipher_tab[k];
        nd++;
        if (dec_lat[k] > TO) begin
          ef[k] = 1'b1;
          elen += enc_lat[k] + TO + 3;
        end else begin
          mdl_plain = ref_block ^ err_tab[k];
          elen += enc_lat[k] + dec_lat[k] + 4;
          if (err_tab[k] == '0) ep[k] = 1'b1;
          else                  ef[k] = 1'b1;
        end
      end
    end
  endtask

  // Launch one run and count the busy cycles until done. Optionally, at loop
  // step poke, pulse go and flip sel while the run is in progress.
  task automatic do_run(input logic [1:0] s, input int poke, output int len, output bit ok);
    n_enc = 0; n_dec = 0;
    klog.delete(); dlog.delete();
    sel = s; go = 1'b1;
    @(negedge clk);
    go = 1'b0; len = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) len++;
      go = (i == poke);
      if (i == poke) sel = ~sel;
      @(negedge clk);
    end
    go = 1'b0;
    $display("run mode=%0d pass=%b fail=%b len=%0d starts=%0d/%0d", s, pass, fail, len, n_enc, n_dec);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({busy, done, pass, fail, enc_start, dec_start, key_len, disp_byte} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, fail, enc_start, dec_start, key_len, disp_byte});
    end
    total++; if (dec_in !== '0) begin bad++; $display("FAIL reset_dec_in: got %h want 0", dec_in); end
    // Abort a run while it waits for the encrypt core.
    enc_lat[0] = 11; enc_en[0] = 1'b1;
    @(negedge clk); sel = 2'b00; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    total++; if ({busy, done, pass, fail, enc_start, dec_start, key_len, disp_byte} !== 20'h0) begin
      bad++;
      $display("FAIL reset_midrun: got %h want 0", {busy, done, pass, fail, enc_start, dec_start, key_len, disp_byte});
    end
    @(negedge clk); reset = 1'b0; n_enc = 0; n_dec = 0;
    repeat (15) @(negedge clk);
    total++; if (n_enc + n_dec != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_pulse: got starts=%0d busy=%b want 0 0", n_enc + n_dec, busy);
    end
    mdl_cipher = '0; mdl_plain = '0;
    $display("reset test complete");
  endtask

  task automatic test_known_vector();
    logic [2:0] ep, ef; int elen, ne, nd, len; bit ok; logic [DW-1:0] sh;
    ref_block = 128'h00112233445566778899aabbccddeeff;
    cipher_tab[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    err_tab[0] = '0; enc_lat[0] = 11; dec_lat[0] = 11; enc_en[0] = 1'b1; disp_sel = 1'b0;
    model(2'b00, ep, ef, elen, ne, nd);
    do_run(2'b00, -1, len, ok);
    total++; if (!ok) begin bad++; $display("FAIL kv_done_timeout: got done=%b want 1", done); end
    total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL kv_passfail: got %b/%b want %b/%b", pass, fail, ep, ef); end
    total++; if (busy !== 1'b0 || key_len !== 2'd0) begin bad++; $display("FAIL kv_idle: got busy=%b key_len=%0d want 0 0", busy, key_len); end
    total++; if (len != elen) begin bad++; $display("FAIL kv_len: got %0d want %0d", len, elen); end
    total++; if (dlog.size() != 1 || dlog[0] !== cipher_tab[0]) begin bad++; $display("FAIL kv_dec_in: got %h want %h", dlog[0], cipher_tab[0]); end
    total++; if (klog.size() != 1 || klog[0] != 0) begin bad++; $display("FAIL kv_key_len: got %0d want 0", klog[0]); end
    total++; if (dec_in !== cipher_tab[0]) begin bad++; $display("FAIL kv_dec_in_hold: got %h want %h", dec_in, cipher_tab[0]); end
    // Scroll through every byte and wrap back to byte 0.
    for (int b = 0; b <= NB; b++) begin
      sh = mdl_cipher >> (8 * (b % NB));
      total++; if (disp_byte !== sh[7:0]) begin bad++; $display("FAIL kv_disp%0d: got %h want %h", b, disp_byte, sh[7:0]); end
      repeat (SC) @(negedge clk);
    end
  endtask

  task automatic test_all_modes();
    logic [2:0] ep, ef; int elen, ne, nd, len; bit ok; logic [DW-1:0] r;
    ref_block = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 3; k++) begin
      cipher_tab[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      err_tab[k] = '0; enc_en[k] = 1'b1;
      enc_lat[k] = 11 + 2 * k; dec_lat[k] = 11 + 2 * k;
    end
    disp_sel = 1'b0;
    model(2'b11, ep, ef, elen, ne, nd);
    do_run(2'b11, -1, len, ok);
    total++; if (!ok) begin bad++; $display("FAIL all_done_timeout: got done=%b want 1", done); end
    total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL all_passfail: got %b/%b want %b/%b", pass, fail, ep, ef); end
    total++; if (len != elen) begin bad++; $display("FAIL all_len: got %0d want %0d", len, elen); end
    total++; if (n_enc != ne || n_dec != nd) begin bad++; $display("FAIL all_starts: got %0d/%0d want %0d/%0d", n_enc, n_dec, ne, nd); end
    for (int k = 0; k < 3; k++) begin
      total++; if (klog.size() != 3 || klog[k] != k || dlog[k] !== cipher_tab[k]) begin
        bad++;
        $display("FAIL all_key%0d: got key_len=%0d dec_in=%h want %0d %h", k, klog[k], dlog[k], k, cipher_tab[k]);
      end
    end
    r = mdl_cipher;
    total++; if (disp_byte !== r[7:0]) begin bad++; $display("FAIL all_disp_cipher: got %h want %h", disp_byte, r[7:0]); end
    disp_sel = 1'b1; #1;
    r = mdl_plain;
    total++; if (disp_byte !== r[7:0]) begin bad++; $display("FAIL all_disp_plain: got %h want %h", disp_byte, r[7:0]); end
    disp_sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mismatch();
    logic [2:0] ep, ef; int elen, ne, nd, len; bit ok; logic [DW-1:0] r;
    ref_block = 128'h00112233445566778899aabbccddeeff;
    cipher_tab[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    err_tab[1] = 128'h1; enc_lat[1] = 9; dec_lat[1] = 7; enc_en[1] = 1'b1; disp_sel = 1'b1;
    model(2'b01, ep, ef, elen, ne, nd);
    do_run(2'b01, -1, len, ok);
    total++; if (!ok) begin bad++; $display("FAIL mm_done_timeout: got done=%b want 1", done); end
    total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL mm_passfail: got %b/%b want %b/%b", pass, fail, ep, ef); end
    total++; if (len != elen) begin bad++; $display("FAIL mm_len: got %0d want %0d", len, elen); end
    r = mdl_plain;
    total++; if (disp_byte !== r[7:0]) begin bad++; $display("FAIL mm_disp: got %h want %h", disp_byte, r[7:0]); end
    disp_sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int nds = 0;
    sel8 = 2'b10; go8 = 1'b1;
    @(negedge clk); go8 = 1'b0;
    total++; if (enc_start8 !== 1'b1 || key_len8 !== 2'd2) begin
      bad++;
      $display("FAIL to_start: got enc_start=%b key_len=%0d want 1 2", enc_start8, key_len8);
    end
    // ENC_WAIT is entered in the next cycle; fail must appear 8 cycles after entry.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (dec_start8) nds++;
      if (i == 8) begin
        total++; if (fail8 !== 3'b000) begin bad++; $display("FAIL to_early: got %b want 000", fail8); end
      end
      if (i == 9) begin
        total++; if (fail8 !== 3'b100 || pass8 !== 3'b000) begin bad++; $display("FAIL to_fail: got %b/%b want 000/100", pass8, fail8); end
      end
    end
    @(negedge clk);
    total++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin bad++; $display("FAIL to_done: got done=%b busy=%b want 1 0", done8, busy8); end
    repeat (10) begin
      @(negedge clk);
      if (dec_start8) nds++;
    end
    total++; if (nds != 0) begin bad++; $display("FAIL to_dec_start: got %0d pulses want 0", nds); end
    $display("timeout run pass=%b fail=%b", pass8, fail8);
  endtask

  task automatic test_back_to_back();
    logic [2:0] ep, ef; int elen, ne, nd, len; bit ok;
    // The encrypt result lands exactly in the timeout cycle; go and sel are disturbed mid-run.
    cipher_tab[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    err_tab[0] = '0; enc_lat[0] = TO; dec_lat[0] = 5; enc_en[0] = 1'b1;
    model(2'b00, ep, ef, elen, ne, nd);
    do_run(2'b00, 5, len, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b1_done_timeout: got done=%b want 1", done); end
    total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL b2b1_passfail: got %b/%b want %b/%b", pass, fail, ep, ef); end
    total++; if (len != elen || n_enc != ne || n_dec != nd) begin
      bad++;
      $display("FAIL b2b1_len: got %0d %0d/%0d want %0d %0d/%0d", len, n_enc, n_dec, elen, ne, nd);
    end
    // Immediately rerun with the decrypt result coincident with the timeout.
    cipher_tab[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
    err_tab[1] = '0; enc_lat[1] = 3; dec_lat[1] = TO; enc_en[1] = 1'b1;
    model(2'b01, ep, ef, elen, ne, nd);
    do_run(2'b01, -1, len, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b2_done_timeout: got done=%b want 1", done); end
    total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL b2b2_passfail: got %b/%b want %b/%b", pass, fail, ep, ef); end
    total++; if (len != elen) begin bad++; $display("FAIL b2b2_len: got %0d want %0d", len, elen); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] ep, ef; int elen, ne, nd, len; bit ok; logic [1:0] mode;
    logic [DW-1:0] one, r;
    one = 1;
    for (int it = 0; it < 10; it++) begin
      mode = 2'($urandom_range(3, 0));
      ref_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int k = 0; k < 3; k++) begin
        enc_lat[k] = $urandom_range(20, 1);
        dec_lat[k] = $urandom_range(20, 1);
        enc_en[k] = ($urandom_range(9, 0) != 0);
        err_tab[k] = ($urandom_range(3, 0) == 0) ? (one << $urandom_range(DW - 1, 0)) : '0;
        cipher_tab[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      disp_sel = $urandom_range(1, 0) != 0;
      model(mode, ep, ef, elen, ne, nd);
      do_run(mode, -1, len, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done_timeout: got done=%b want 1", it, done); end
      total++; if (pass !== ep || fail !== ef) begin bad++; $display("FAIL rnd%0d_passfail: got %b/%b want %b/%b", it, pass, fail, ep, ef); end
      total++; if (len != elen || n_enc != ne || n_dec != nd) begin
        bad++;
        $display("FAIL rnd%0d_len: got %0d %0d/%0d want %0d %0d/%0d", it, len, n_enc, n_dec, elen, ne, nd);
      end
      r = disp_sel ? mdl_plain : mdl_cipher;
      total++; if (disp_byte !== r[7:0]) begin bad++; $display("FAIL rnd%0d_disp: got %h want %h", it, disp_byte, r[7:0]); end
      repeat (6) @(negedge clk);
    end
    disp_sel = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      enc_lat[k] = 1; dec_lat[k] = 1; enc_en[k] = 1'b1;
      cipher_tab[k] = '0; err_tab[k] = '0;
    end
    test_reset();
    test_known_vector();
    test_all_modes();
    test_mismatch();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
